spi_master: RTL and testbench
=============================

# spi_master

Single-clock SPI master that generates `ss`, `sck` and `mosi` and captures `miso`. It sits directly upstream of the slave-side transmitter: it drives that block's `ss`/`sck` inputs and consumes the serial `tx` it produces. Framing is LSB first, with `sck` idling high. The slave updates on the falling `sck` edge and the master samples on the rising edge. A start/busy/done handshake connects it to the system-side logic.

## Interface
- `DATA_LENGTH`, 8: bits per transfer; range 2..16.
- `CLK_DIV`, 4: `clk` cycles per `sck` half-period; range ≥1.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a transfer; sampled only when `busy`=0.
- `data_in`  in  `DATA_LENGTH`  word to shift out on `mosi`; captured when `start` is accepted.
- `data_out`  out  `DATA_LENGTH`  word received on `miso`; updated only in the `done` cycle, held otherwise.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse marking transfer complete.
- `ss`  out  1  slave select, active low.
- `sck`  out  1  serial clock; idles high.
- `mosi`  out  1  serial data out, LSB first.
- `miso`  in  1  serial data in, LSB first; treated as synchronous to `clk`.

## Operation
- Reset values: `ss`=1, `sck`=1, `mosi`=0, `busy`=0, `done`=0, `data_out`=0. Internal counters and shift registers are cleared and the FSM enters IDLE.
- FSM states: IDLE → SETUP → LOW → HIGH → (LOW | HOLD) → IDLE.
  - **IDLE:** `start`=1 latches `data_in` into the tx shifter, sets `ss`=0 and `busy`=1, then enters SETUP.
  - **SETUP:** `CLK_DIV` cycles with `ss` low and `sck` high. On exit, `sck`=0 and `mosi`=tx bit 0, then LOW.
  - **LOW:** `CLK_DIV` cycles. On exit, `sck`=1 and `miso` is shifted into rx bit i, then HIGH.
  - **HIGH:** `CLK_DIV` cycles.
    - If i < `DATA_LENGTH`-1: on exit, `sck`=0, `mosi`=tx bit i+1, i increments, then LOW.
    - Otherwise: go to HOLD.
  - **HOLD:** `CLK_DIV` cycles with `sck` high. On exit, `ss`=1, `busy`=0, `done`=1, `data_out`=rx shifter, then IDLE.
- `start` while `busy`=1 is ignored; nothing is queued.
- `start`=1 in the `done` cycle is accepted. `ss` is then high for exactly 1 cycle between frames.
- `mosi` holds its last bit through HOLD and returns to 0 in IDLE.
- Reset mid-transfer: the frame is abandoned, all outputs return to their reset values on the next edge, and no `done` pulse is issued.
- Bit counter width is $clog2(`DATA_LENGTH`)+1. The divider counter counts 0..`CLK_DIV`-1 and wraps.

## Timing
- Let edge 0 be the `clk` edge that accepts `start`.
- After edge 0: `ss`=0, `busy`=1.
- First `sck` fall: after edge `CLK_DIV`.
- Rising edge for bit i: after edge `CLK_DIV`·(2i+2). `miso` is captured on that same edge.
  - The slave launches each bit at the preceding `sck` fall, so `miso` has `CLK_DIV` cycles to settle.
- Last `sck` rise: after edge 2·`CLK_DIV`·`DATA_LENGTH`.
- `done`: after edge `CLK_DIV`·(2·`DATA_LENGTH`+1), i.e. 68 cycles for the default parameters. `done` lasts exactly 1 cycle.
- `sck` duty cycle is exactly 50%. The `sck` period is 2·`CLK_DIV` cycles.
- No combinational path from `miso` or `start` to any output.

## Structure
- Shared package `spi_pkg` holds:
  - the FSM state encoding (IDLE, SETUP, LOW, HIGH, HOLD);
  - the constants `SCK_IDLE`=1 and `SS_ACTIVE`=0.
- One sub-module: `spi_sck_gen`, a divider counter with `clk`, `rst`, `en` and a `tick` pulse every `CLK_DIV` cycles. The FSM advances only on `tick`.
- Tx and rx shift registers stay in the top module.

## Test plan
- **Loopback:** `mosi` tied to `miso`, default parameters, `data_in`=0xA5, `start` for 1 cycle → `done` 68 cycles later, `data_out`=0xA5, `busy` high for exactly 68 cycles, 8 `sck` falls.
- **Slave model:** a behavioural slave updates `miso` on `sck` fall, LSB first, with 0x3C; `data_in`=0xFF → `data_out`=0x3C; `mosi` observed on `sck` rises is 1,1,1,1,1,1,1,1.
- **Start while busy:** `start` pulsed at cycles 10 and 40 of a frame → one frame only, one `done`, `data_out` unchanged by the extra pulses.
- **Back-to-back:** `start` held high → the second frame begins in the `done` cycle, `ss` high for exactly 1 cycle, second `done` at cycle 137.
- **Reset mid-frame:** `rst` at cycle 20 → next edge gives `ss`=1, `sck`=1, `mosi`=0, `busy`=0, `data_out`=0, and `done` never pulses.
- **Minimum divider:** `CLK_DIV`=1, `DATA_LENGTH`=4, loopback 0x9 → `done` after 9 cycles, `data_out`=0x9, `sck` toggles every cycle.

Source files
------------

// File: rtl/spi_pkg.sv
// ============================================================================
// Module      : spi_pkg
// Description : Shared FSM encoding and line-level constants for spi_master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_HOLD  = 3'd4
  } spi_state_e;

  localparam logic SCK_IDLE  = 1'b1;
  localparam logic SS_ACTIVE = 1'b0;

endpackage

`default_nettype wire

// File: rtl/spi_master_if.sv
// ============================================================================
// Module      : spi_master_if
// Description : Handshake and serial-line bundle between spi_master and peers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_master_if #(
  parameter int DATA_LENGTH = 8
);

  logic                   start;
  logic [DATA_LENGTH-1:0] data_in;
  logic [DATA_LENGTH-1:0] data_out;
  logic                   busy;
  logic                   done;
  logic                   ss;
  logic                   sck;
  logic                   mosi;
  logic                   miso;

  modport master (
    input  start, data_in, miso,
    output data_out, busy, done, ss, sck, mosi
  );

  modport slave (
    output start, data_in, miso,
    input  data_out, busy, done, ss, sck, mosi
  );

endinterface

`default_nettype wire

// File: rtl/spi_sck_gen.sv
// ============================================================================
// Module      : spi_sck_gen
// Description : Divider producing a one-cycle tick every CLK_DIV enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int              CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]   C_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Held at zero while disabled so every phase starts a full CLK_DIV period.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_cnt <= '0;
    end else if (r_cnt == C_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = en && (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
// ============================================================================
// Module      : spi_master
// Description : LSB-first SPI master, sck idles high, samples miso on sck rise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_LENGTH = 8,
  parameter int CLK_DIV     = 4
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.master bus
);

  localparam int            BW         = $clog2(DATA_LENGTH) + 1;
  localparam logic [BW-1:0] C_LAST_BIT = BW'(DATA_LENGTH - 1);

  spi_state_e             r_state;
  logic [DATA_LENGTH-1:0] r_tx;
  logic [DATA_LENGTH-1:0] r_rx;
  logic [DATA_LENGTH-1:0] r_data_out;
  logic [BW-1:0]          r_bit;
  logic                   r_ss;
  logic                   r_sck;
  logic                   r_mosi;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_en;
  logic                   w_tick;

  assign w_en = (r_state != ST_IDLE);

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (w_en),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_tx       <= '0;
      r_rx       <= '0;
      r_data_out <= '0;
      r_bit      <= '0;
      r_ss       <= ~SS_ACTIVE;
      r_sck      <= SCK_IDLE;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_tx    <= bus.data_in;
            r_rx    <= '0;
            r_bit   <= '0;
            r_ss    <= SS_ACTIVE;
            r_busy  <= 1'b1;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_tick) begin
            r_sck   <= ~SCK_IDLE;
            r_mosi  <= r_tx[0];
            r_tx    <= r_tx >> 1;
            r_state <= ST_LOW;
          end
        end
        ST_LOW: begin
          // The last bit's high half-period doubles as HOLD, so done lands
          // CLK_DIV*(2*DATA_LENGTH+1) cycles after start.
          if (w_tick) begin
            r_sck   <= SCK_IDLE;
            r_rx    <= {bus.miso, r_rx[DATA_LENGTH-1:1]};
            r_state <= (r_bit == C_LAST_BIT) ? ST_HOLD : ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_tick) begin
            r_sck   <= ~SCK_IDLE;
            r_mosi  <= r_tx[0];
            r_tx    <= r_tx >> 1;
            r_bit   <= r_bit + 1'b1;
            r_state <= ST_LOW;
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_ss       <= ~SS_ACTIVE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_data_out <= r_rx;
            r_mosi     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ss       = r_ss;
  assign bus.sck      = r_sck;
  assign bus.mosi     = r_mosi;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.data_out = r_data_out;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
// Module      : tb_spi_master
// Description : Scoreboard bench for spi_master (default and minimum divider).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_if #(.DATA_LENGTH(8)) a_if ();
  spi_master_if #(.DATA_LENGTH(4)) b_if ();

  spi_master #(.DATA_LENGTH(8), .CLK_DIV(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  spi_master #(.DATA_LENGTH(4), .CLK_DIV(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  logic       loop = 1'b1;
  logic       slave_miso = 1'b0;
  logic [7:0] slave_word = 8'h00;
  int         sidx = 0;

  assign a_if.miso = loop ? a_if.mosi : slave_miso;
  assign b_if.miso = b_if.mosi;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [3:0] exp_qb[$];

  logic       obs_on = 1'b0;
  int         cyc = 0;
  int         busy_n, fall_n, ss_hi_n, done_n, ss_win;
  int         done_at[$];
  logic       prev_sck;
  logic [7:0] mosi_log;
  int         mosi_rise_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; busy_n = 0; fall_n = 0; ss_hi_n = 0; done_n = 0;
    done_at.delete();
    prev_sck = 1'b1;
    obs_on = 1'b1;
  endtask

  function automatic int first_done(input int idx);
    return (done_at.size() > idx) ? done_at[idx] : -1;
  endfunction

  // Launch a frame on DUT A; edge 0 is the posedge that samples start.
  task automatic launch_a(input logic [7:0] d, input logic [7:0] expv, input bit push, input bit hold);
    @(posedge clk); #1;
    a_if.start = 1'b1; a_if.data_in = d;
    @(posedge clk);
    if (push) exp_q.push_back(expv);
    #1;
    if (!hold) a_if.start = 1'b0;
    clear_stats();
  endtask

  initial begin
    a_if.start = 1'b0; a_if.data_in = '0;
    b_if.start = 1'b0; b_if.data_in = '0;
    ss_win = 100000;
    mosi_log = '0; mosi_rise_n = 0;

    fork
      begin : scoreboard
        forever begin
          @(negedge clk);
          if (a_if.done === 1'b1) begin
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL a_unexpected_done: actual=done required=none");
            end else begin
              check("a_data_out", 32'(a_if.data_out), 32'(exp_q.pop_front()));
            end
          end
          if (b_if.done === 1'b1) begin
            if (exp_qb.size() == 0) begin
              total++; bad++;
              $display("FAIL b_unexpected_done: actual=done required=none");
            end else begin
              check("b_data_out", 32'(b_if.data_out), 32'(exp_qb.pop_front()));
            end
          end
        end
      end
      begin : observer
        forever begin
          @(negedge clk);
          if (obs_on) begin
            if (a_if.busy === 1'b1) busy_n++;
            if (prev_sck === 1'b1 && a_if.sck === 1'b0) fall_n++;
            prev_sck = a_if.sck;
            if (cyc >= 1 && cyc <= ss_win && a_if.ss === 1'b1) ss_hi_n++;
            if (a_if.done === 1'b1) begin
              done_n++;
              done_at.push_back(cyc);
            end
            cyc++;
          end
        end
      end
      begin : slave_model
        forever begin
          @(negedge a_if.sck);
          if (a_if.ss === 1'b0 && !loop) begin
            slave_miso = slave_word[sidx[2:0]];
            sidx++;
          end
        end
      end
      begin : mosi_logger
        forever begin
          @(posedge a_if.sck);
          if (a_if.ss === 1'b0) begin
            mosi_log = {a_if.mosi, mosi_log[7:1]};
            mosi_rise_n++;
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ss",       32'(a_if.ss),       32'd1);
    check("rst_sck",      32'(a_if.sck),      32'd1);
    check("rst_mosi",     32'(a_if.mosi),     32'd0);
    check("rst_busy",     32'(a_if.busy),     32'd0);
    check("rst_done",     32'(a_if.done),     32'd0);
    check("rst_data_out", 32'(a_if.data_out), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Loopback 0xA5
    loop = 1'b1;
    launch_a(8'hA5, 8'hA5, 1'b1, 1'b0);
    repeat (80) @(negedge clk);
    check("lb_done_count", 32'(done_n), 32'd1);
    check("lb_done_cycle", 32'(first_done(0)), 32'd68);
    check("lb_busy_cycles", 32'(busy_n), 32'd68);
    check("lb_sck_falls", 32'(fall_n), 32'd8);

    // Behavioural slave returning 0x3C
    loop = 1'b0; slave_word = 8'h3C; sidx = 0; slave_miso = 1'b0;
    mosi_log = '0; mosi_rise_n = 0;
    launch_a(8'hFF, 8'h3C, 1'b1, 1'b0);
    repeat (80) @(negedge clk);
    check("sl_done_cycle", 32'(first_done(0)), 32'd68);
    check("sl_mosi_bits", 32'(mosi_log), 32'hFF);
    check("sl_sck_rises", 32'(mosi_rise_n), 32'd8);

    // Extra start pulses while busy are ignored
    loop = 1'b1;
    launch_a(8'h5A, 8'h5A, 1'b1, 1'b0);
    repeat (10) @(posedge clk); #1;
    a_if.start = 1'b1; a_if.data_in = 8'hC3;
    @(posedge clk); #1 a_if.start = 1'b0;
    repeat (28) @(posedge clk); #1;
    a_if.start = 1'b1;
    @(posedge clk); #1 a_if.start = 1'b0;
    repeat (110) @(negedge clk);
    check("sb_done_count", 32'(done_n), 32'd1);
    check("sb_done_cycle", 32'(first_done(0)), 32'd68);
    check("sb_busy_cycles", 32'(busy_n), 32'd68);

    // Back-to-back with start held high
    ss_win = 136;
    launch_a(8'h81, 8'h81, 1'b1, 1'b1);
    a_if.data_in = 8'h42;
    repeat (69) @(posedge clk);
    exp_q.push_back(8'h42);
    #1 a_if.start = 1'b0;
    repeat (80) @(negedge clk);
    check("bb_done_count", 32'(done_n), 32'd2);
    check("bb_done1_cycle", 32'(first_done(0)), 32'd68);
    check("bb_done2_cycle", 32'(first_done(1)), 32'd137);
    check("bb_ss_gap", 32'(ss_hi_n), 32'd1);
    check("bb_busy_cycles", 32'(busy_n), 32'd136);
    ss_win = 100000;

    // Reset mid-frame while sck is low and mosi is high
    launch_a(8'h77, 8'h00, 1'b0, 1'b0);
    repeat (20) @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mr_ss",       32'(a_if.ss),       32'd1);
    check("mr_sck",      32'(a_if.sck),      32'd1);
    check("mr_mosi",     32'(a_if.mosi),     32'd0);
    check("mr_busy",     32'(a_if.busy),     32'd0);
    check("mr_data_out", 32'(a_if.data_out), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (100) @(negedge clk);
    check("mr_no_done", 32'(done_n), 32'd0);
    obs_on = 1'b0;

    // Minimum divider instance: CLK_DIV=1, DATA_LENGTH=4, loopback 0x9
    begin
      int   tog;
      int   bdone;
      logic ps;
      tog = 0; bdone = -1; ps = 1'b1;
      @(posedge clk); #1;
      b_if.start = 1'b1; b_if.data_in = 4'h9;
      @(posedge clk);
      exp_qb.push_back(4'h9);
      #1 b_if.start = 1'b0;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (k > 0 && k <= 8 && b_if.sck !== ps) tog++;
        ps = b_if.sck;
        if (b_if.done === 1'b1 && bdone < 0) bdone = k;
      end
      check("md_sck_toggles", 32'(tog), 32'd8);
      check("md_done_cycle", 32'(bdone), 32'd9);
    end

    repeat (4) @(negedge clk);
    check("a_queue_drained", 32'(exp_q.size()), 32'd0);
    check("b_queue_drained", 32'(exp_qb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
